// File: rtl/key_debounce.sv
// key_debounce: per-bit synchronized push-button debouncer sampled on de_clk rising edges,
// producing a debounced level plus one-clk press/release pulses.
module key_debounce #(
    parameter int WIDTH  = 5,
    parameter int STABLE = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             de_clk,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic             any_press
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;
    localparam logic [3:0] LAST         = 4'(STABLE - 1);

    logic [WIDTH-1:0] sync_a, sync_b, press_nx, rel_nx;
    logic             de_q, tick;

    assign tick = de_clk & ~de_q;

    // de_q resets high so a de_clk already high at reset release is not a tick
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_a <= '0;
            sync_b <= '0;
            de_q   <= 1'b1;
        end else begin
            sync_a <= key_in;
            sync_b <= sync_a;
            de_q   <= de_clk;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic [1:0] st, st_nx;
            logic [3:0] cnt, cnt_nx;
            logic       s, pr, rl;
            assign s           = sync_b[i];
            assign press_nx[i] = pr;
            assign rel_nx[i]   = rl;
            always_comb begin
                st_nx  = st;
                cnt_nx = cnt;
                pr     = 1'b0;
                rl     = 1'b0;
                if (tick) begin
                    case (st)
                        IDLE: if (s) begin
                            st_nx  = PRESS_WAIT;
                            cnt_nx = 4'd1;
                        end
                        PRESS_WAIT: if (!s) begin
                            st_nx  = IDLE;
                            cnt_nx = 4'd0;
                        end else if (cnt == LAST) begin
                            st_nx  = PRESSED;
                            cnt_nx = 4'd0;
                            pr     = 1'b1;
                        end else cnt_nx = cnt + 4'd1;
                        PRESSED: if (!s) begin
                            st_nx  = RELEASE_WAIT;
                            cnt_nx = 4'd1;
                        end
                        default: if (s) begin
                            st_nx  = PRESSED;
                            cnt_nx = 4'd0;
                        end else if (cnt == LAST) begin
                            st_nx  = IDLE;
                            cnt_nx = 4'd0;
                            rl     = 1'b1;
                        end else cnt_nx = cnt + 4'd1;
                    endcase
                end
            end
            always_ff @(posedge clk) begin
                if (clr) begin
                    st  <= IDLE;
                    cnt <= 4'd0;
                end else begin
                    st  <= st_nx;
                    cnt <= cnt_nx;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_press   <= 1'b0;
        end else begin
            key_level   <= (key_level | press_nx) & ~rel_nx;
            key_press   <= press_nx;
            key_release <= rel_nx;
            any_press   <= |press_nx;
        end
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter WIDTH, default 5: number of independent push-button inputs, 1..16.
REQ-002 Parameter STABLE, default 3: consecutive equal samples needed to accept a level change, 2..15.
REQ-003 Port clk  input  1: system clock; all logic on rising edge.
REQ-004 Port clr  input  1: reset; synchronous, active-high.
REQ-005 Port de_clk  input  1: divided debounce clock (level), same clk domain; each rising edge is one sample point.
REQ-006 Port key_in  input  WIDTH: raw asynchronous button levels; 1 = pressed.
REQ-007 Port key_level  output  WIDTH: debounced button state; 1 = pressed.
REQ-008 Port key_press  output  WIDTH: one-clk pulse per accepted press, per bit.
REQ-009 Port key_release  output  WIDTH: one-clk pulse per accepted release, per bit.
REQ-010 Port any_press  output  1: registered OR of key_press; high in the same cycle as key_press.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer per bit before any use; sync value = second flop.
REQ-012 de_clk SHALL be registered once (de_q); tick = de_clk & ~de_q; tick is high for exactly one clk per de_clk rising edge.
REQ-013 Each bit SHALL own an independent FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus counter cnt of 4 bits.
REQ-014 FSM and cnt SHALL change only in tick cycles; non-tick cycles hold everything except pulse outputs, which clear.
REQ-015 IDLE, tick, sync=1 -> PRESS_WAIT, cnt=1; sync=0 -> stay IDLE.
REQ-016 PRESS_WAIT, tick, sync=1: cnt+1==STABLE -> PRESSED, cnt=0, key_level=1, key_press=1 next cycle; else cnt=cnt+1.
REQ-017 PRESS_WAIT, tick, sync=0 -> IDLE, cnt=0, no pulse (bounce rejected).
REQ-018 PRESSED, tick, sync=0 -> RELEASE_WAIT, cnt=1; sync=1 -> stay.
REQ-019 RELEASE_WAIT, tick, sync=0: cnt+1==STABLE -> IDLE, cnt=0, key_level=0, key_release=1 next cycle; else cnt=cnt+1.
REQ-020 RELEASE_WAIT, tick, sync=1 -> PRESSED, cnt=0, no pulse.
REQ-021 key_level, key_press, key_release, any_press SHALL be registered; key_level changes in the same cycle its pulse asserts.
REQ-022 key_press and key_release SHALL be single-cycle pulses; never both high on one bit.
REQ-023 Latency: sampled level first seen at tick k -> pulse in cycle after tick k+STABLE-1; key_in to sync is 2 clk.
REQ-024 Bits SHALL be independent; simultaneous presses on several bits SHALL produce simultaneous pulses on each.
REQ-025 cnt SHALL never exceed STABLE-1 and never wraps.
REQ-026 A button held continuously SHALL produce exactly one key_press, no repeat.

Reset
REQ-027 clr=1 at a clk edge: all FSMs IDLE, cnt=0, synchronizer flops 0, all outputs 0.
REQ-028 de_q SHALL reset to 1 so a de_clk already high at reset release produces no tick.
REQ-029 clr asserted mid-debounce (any state) SHALL abort it with no pulse; clr has priority over tick.
REQ-030 A button held through reset release SHALL be accepted as a fresh press after STABLE ticks.

Verification (WIDTH=5, STABLE=3, bench drives de_clk period 16 clk)
REQ-031 key_in[0] 0->1 held -> key_press[0] and any_press one clk high after 3rd tick sampling 1; key_level[0]=1; no further pulses.
REQ-032 key_in[1] pattern 1,0,1,1,0 per tick -> no key_press[1], key_level[1] stays 0.
REQ-033 key_in[2] pressed then released, 3 stable ticks each -> one key_press[2], then one key_release[2]; key_level[2] 1 then 0.
REQ-034 key_in=5'b10001 on same clk -> key_press=5'b10001 in one cycle, any_press=1 once.
REQ-035 clr pulsed during PRESS_WAIT of bit 3 -> no pulse, outputs 0; with key held, press accepted 3 ticks after clr drops.
REQ-036 clr released with de_clk=1 -> no tick until next de_clk 0->1 edge; checked via cnt/state not advancing.
